// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: N-channel, W-bit registered stream mux; grant by external select or round-robin.
// Define STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat (packet lock).
module stream_mux_nto1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Handshake: a beat moves on a rising edge where valid and ready are both 1. Valid never
    // waits for ready; in_ready depends only on the grant and on the output register having room.
    localparam logic [SEL_W:0]   CHAN_LIM = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

    logic             load;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             sel_valid;
    logic             xfer;
    logic             rr_adv;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] ptr_next;

`ifdef STREAM_MUX_LOCK_EN
    logic             lock_active;
    logic [SEL_W-1:0] lock_chan;
`endif

    assign load = out_ready | ~out_valid;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
`ifdef STREAM_MUX_LOCK_EN
        if (lock_active) begin
            grant_vld = 1'b1;
            grant_idx = lock_chan;
        end else
`endif
        if (!mode) begin
            grant_vld = ({1'b0, sel} < CHAN_LIM);
            grant_idx = sel;
        end else begin
            // Two passes: channels at or above rr_ptr first, then wrap to the low ones.
            for (int k = 0; k < CHANNELS; k++) begin
                if (!grant_vld && in_valid[k] && (SEL_W'(k) >= rr_ptr)) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (!grant_vld && in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        in_ready  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                sel_data    = in_data[k*WIDTH +: WIDTH];
                sel_last    = in_last[k];
                sel_valid   = in_valid[k];
                in_ready[k] = grant_vld & load & rst_n;
            end
        end
    end

    assign xfer     = grant_vld & load & sel_valid & rst_n;
    assign ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);

`ifdef STREAM_MUX_LOCK_EN
    assign rr_adv = sel_last;
`else
    assign rr_adv = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_data  <= sel_data;
                out_chan  <= grant_idx;
                out_last  <= sel_last;
                out_valid <= 1'b1;
            end else if (load) begin
                out_valid <= 1'b0;
            end
            if (xfer && mode && rr_adv) begin
                rr_ptr <= ptr_next;
            end
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_chan   <= '0;
        end else if (xfer) begin
            lock_active <= ~sel_last;
            lock_chan   <= grant_idx;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb_stream_mux_nto1: directed scenarios plus randomized traffic against a beat-level reference model.
module tb_stream_mux_nto1;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic [SW-1:0] sel;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0] in_valid;
    logic [CH-1:0] in_last;
    logic [CH-1:0] in_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_chan;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    int passed = 0;
    int total  = 0;

    // reference model state
    logic [SW+W:0] exp_q[$];
    logic          m_valid;
    int            m_ptr;
    logic          m_lock;
    int            m_lock_ch;

    stream_mux_nto1 #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // grant predicted from the rules: lock, then external select, then round-robin search
    function automatic int model_grant();
        int k;
        if (m_lock) return m_lock_ch;
        if (!mode) return (int'(sel) < CH) ? int'(sel) : -1;
        for (int i = 0; i < CH; i++) begin
            k = (m_ptr + i) % CH;
            if (in_valid[k[1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        for (int n = 0; n < 4; n++) begin
            mode      = 1'($urandom);
            sel       = 3'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            in_data   = $urandom;
            out_ready = 1'($urandom);
            @(negedge clk);
            total++;
            if (in_ready !== 4'b0) $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
            else passed++;
            total++;
            if ({out_valid, out_last, out_chan, out_data} !== 13'h0)
                $display("FAIL reset_outputs: got v=%b l=%b c=%0d d=%02h expected all 0",
                         out_valid, out_last, out_chan, out_data);
            else passed++;
            @(posedge clk);
            #1;
        end
        mode = 1'b0; sel = 3'd1; in_valid = 4'hf; in_last = 4'h0;
        in_data = 32'h44332211; out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 4'b0010) $display("FAIL first_grant_ready: got %b expected 0010", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h22)
            $display("FAIL first_grant_data: got v=%b d=%02h expected v=1 d=22", out_valid, out_data);
        else passed++;
    endtask

    task automatic test_ext_select();
        mode = 1'b0; sel = 3'd2; in_valid = 4'hf; in_data = 32'h44332211; out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 4'b0100) $display("FAIL sel2_ready: got %b expected 0100", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_data !== 8'h33 || out_chan !== 3'd2 || out_valid !== 1'b1)
            $display("FAIL sel2_out: got d=%02h c=%0d v=%b expected d=33 c=2 v=1", out_data, out_chan, out_valid);
        else passed++;
        for (int s = 4; s <= 5; s++) begin
            sel = 3'(s);
            @(negedge clk);
            total++;
            if (in_ready !== 4'b0) $display("FAIL sel_oob_ready: sel=%0d got %b expected 0000", s, in_ready);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0 || out_data !== 8'h33)
                $display("FAIL sel_oob_out: sel=%0d got v=%b d=%02h expected v=0 d=33", s, out_valid, out_data);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1'b1; in_valid = 4'hf; in_last = 4'hf; in_data = 32'hd3c2b1a0; out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_chan !== 3'(n % CH) || out_valid !== 1'b1 || out_data !== 8'(32'hd3c2b1a0 >> (8 * (n % CH))))
                $display("FAIL rr_all: beat %0d got c=%0d v=%b d=%02h expected c=%0d v=1",
                         n, out_chan, out_valid, out_data, n % CH);
            else passed++;
        end
        do_reset();
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_chan !== ((n % 2 == 0) ? 3'd1 : 3'd3))
                $display("FAIL rr_sparse: beat %0d got c=%0d expected %0d", n, out_chan, (n % 2 == 0) ? 1 : 3);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 3'd1; in_valid = 4'hf; in_data = 32'h0000aa00; out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'haa)
            $display("FAIL bp_fill: got v=%b d=%02h expected v=1 d=aa", out_valid, out_data);
        else passed++;
        out_ready = 1'b0;
        in_data   = 32'h0000bb00;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 4'b0) $display("FAIL bp_ready: cycle %0d got %b expected 0000", n, in_ready);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'haa)
                $display("FAIL bp_hold: cycle %0d got v=%b d=%02h expected v=1 d=aa", n, out_valid, out_data);
            else passed++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b expected 0010", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hbb)
            $display("FAIL bp_release_out: got v=%b d=%02h expected v=1 d=bb", out_valid, out_data);
        else passed++;
    endtask

    task automatic test_random();
        int            g;
        logic          ld;
        logic [CH-1:0] exp_rdy;
        logic [SW+W:0] beat;
        do_reset();
        exp_q.delete();
        m_valid = 1'b0; m_ptr = 0; m_lock = 1'b0; m_lock_ch = 0;
        for (int n = 0; n < 400; n++) begin
            mode      = 1'($urandom);
            sel       = 3'($urandom_range(0, 5));
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g  = model_grant();
            ld = out_ready || !m_valid;
            exp_rdy = (g >= 0 && ld) ? (4'b0001 << g[1:0]) : 4'b0000;
            total++;
            if (in_ready !== exp_rdy)
                $display("FAIL rand_ready: cycle %0d got %b expected %b", n, in_ready, exp_rdy);
            else passed++;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_accept: cycle %0d got beat c=%0d d=%02h expected none", n, out_chan, out_data);
                end else begin
                    beat = exp_q.pop_front();
                    if ({out_chan, out_last, out_data} !== beat)
                        $display("FAIL rand_beat: cycle %0d got %03h expected %03h", n,
                                 {out_chan, out_last, out_data}, beat);
                    else passed++;
                end
            end
            if (g >= 0 && ld && in_valid[g[1:0]]) begin
                exp_q.push_back({3'(g), in_last[g[1:0]], 8'(in_data >> (8 * g))});
                m_valid = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
                if (mode && in_last[g[1:0]]) m_ptr = (g + 1) % CH;
                m_lock    = !in_last[g[1:0]];
                m_lock_ch = g;
`else
                if (mode) m_ptr = (g + 1) % CH;
`endif
            end else if (ld) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== m_valid)
                $display("FAIL rand_valid: cycle %0d got %b expected %b", n, out_valid, m_valid);
            else passed++;
        end
        total++;
        if (exp_q.size() != (m_valid ? 1 : 0))
            $display("FAIL rand_queue_end: got %0d pending expected %0d", exp_q.size(), m_valid ? 1 : 0);
        else passed++;
    endtask

`ifdef STREAM_MUX_LOCK_EN
    task automatic test_packet_lock();
        do_reset();
        mode = 1'b1; in_valid = 4'b0011; in_data = 32'h0000_1f0f; out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_last = (b == 2) ? 4'b0011 : 4'b0010;
            @(posedge clk);
            #1;
            total++;
            if (out_chan !== 3'd0 || out_last !== (b == 2))
                $display("FAIL lock_beat: beat %0d got c=%0d l=%b expected c=0 l=%b", b, out_chan, out_last, b == 2);
            else passed++;
        end
        @(posedge clk);
        #1;
        total++;
        if (out_chan !== 3'd1 || out_valid !== 1'b1)
            $display("FAIL lock_release: got c=%0d v=%b expected c=1 v=1", out_chan, out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        mode = 1'b0; sel = 3'd2; in_valid = 4'b0100; in_last = 4'b0000; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_chan !== 3'd2) $display("FAIL midpkt_beat: got c=%0d expected 2", out_chan);
        else passed++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode = 1'b1; in_valid = 4'hf; in_last = 4'hf;
        @(posedge clk);
        #1;
        total++;
        if (out_chan !== 3'd0 || out_valid !== 1'b1)
            $display("FAIL midpkt_after_reset: got c=%0d v=%b expected c=0 v=1", out_chan, out_valid);
        else passed++;
    endtask
`endif

    initial begin
        mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b0;
        test_reset();
        test_ext_select();
        test_round_robin();
        test_backpressure();
        test_random();
`ifdef STREAM_MUX_LOCK_EN
        test_packet_lock();
        test_reset_mid_packet();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
